// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage general-purpose register file.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Architectural zero register: writes are dropped, reads return 0.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: a NUM_REGS:1 mux over the storage array.
// Address ZERO_REG is forced to 0 here, so the zero register never depends
// on what the storage happens to hold.
module regfile_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                addr,
  output logic [DATA_W-1:0]                data
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Select the addressed register, masking the hardwired zero register.
  always_comb begin
    data = '0;
    if (addr != ZERO_ADDR) begin
      data = regs[addr];
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// MIPS-style register file: 2**ADDR_W x DATA_W storage, two independent
// combinational read ports (rs/rt) and one synchronous write port.
// There is no write-to-read bypass: a read of the register being written
// shows the old value until the writing edge. Forwarding lives upstream.
// No handshake: en_write is a plain qualifier sampled on the rising edge;
// reads have no valid/ready and are always available.
module register_file #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_write,
  input  logic [ADDR_W-1:0] read_add1,
  input  logic [ADDR_W-1:0] read_add2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_data
);

  import regfile_pkg::*;

  localparam int                NREGS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         write_hit;

  // A write is only accepted for a non-zero destination.
  assign write_hit = en_write && (write_add != ZERO_ADDR);

  // Storage: async clear on rst low, otherwise load the addressed register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else if (write_hit) begin
      regs[write_add] <= write_data;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .regs (regs),
    .addr (read_add1),
    .data (read_data1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .regs (regs),
    .addr (read_add2),
    .data (read_data2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file: async reset, basic writes, enable gating,
// zero register, same-cycle hazard, mid-operation reset and a full sweep.
module tb_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              clk_en;
  logic              rst;
  logic              en_write;
  logic [ADDR_W-1:0] read_add1;
  logic [ADDR_W-1:0] read_add2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [ADDR_W-1:0] write_add;
  logic [DATA_W-1:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];

  register_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_write   (en_write),
    .read_add1  (read_add1),
    .read_add2  (read_add2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_add  (write_add),
    .write_data (write_data)
  );

  // Clock / reset block: the clock is gated so reset can be shown clockless.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Single comparison point; every check goes through here.
  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present a write at the falling edge so it lands on the next rise.
  task automatic drive_write(input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
    @(negedge clk);
    en_write   = 1'b1;
    write_add  = addr;
    write_data = data;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    en_write = 1'b0;
  endtask

  task automatic read_pair(input logic [ADDR_W-1:0] a1,
                           input logic [ADDR_W-1:0] a2);
    read_add1 = a1;
    read_add2 = a2;
    #1;
  endtask

  initial begin
    clk_en     = 1'b0;
    rst        = 1'b1;
    en_write   = 1'b0;
    read_add1  = '0;
    read_add2  = '0;
    write_add  = '0;
    write_data = '0;

    // Reset with no clock edge at all.
    #2 rst = 1'b0;
    #1;
    read_pair(5'd0, 5'd0);
    check_eq("rst_rd1_a0", read_data1, 32'd0);
    check_eq("rst_rd2_a0", read_data2, 32'd0);
    read_pair(5'd10, 5'd10);
    check_eq("rst_rd1_a10", read_data1, 32'd0);
    check_eq("rst_rd2_a10", read_data2, 32'd0);
    read_pair(5'd31, 5'd31);
    check_eq("rst_rd1_a31", read_data1, 32'd0);
    check_eq("rst_rd2_a31", read_data2, 32'd0);

    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Basic writes on consecutive edges.
    drive_write(5'd10, 32'd101);
    drive_write(5'd11, 32'd200);
    drive_idle();
    read_pair(5'd10, 5'd11);
    check_eq("wr_r10", read_data1, 32'd101);
    check_eq("wr_r11", read_data2, 32'd200);

    // Enable gating across several edges.
    @(negedge clk);
    en_write   = 1'b0;
    write_add  = 5'd10;
    write_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    read_pair(5'd10, 5'd11);
    check_eq("gate_r10", read_data1, 32'd101);
    check_eq("gate_r11", read_data2, 32'd200);

    // Zero register ignores writes.
    drive_write(5'd0, 32'hFFFF_FFFF);
    drive_idle();
    read_pair(5'd0, 5'd0);
    check_eq("zero_rd1", read_data1, 32'd0);
    check_eq("zero_rd2", read_data2, 32'd0);

    // Same-cycle hazard: old value before the edge, new one after.
    drive_write(5'd5, 32'd55);
    read_pair(5'd5, 5'd5);
    check_eq("haz_before", read_data1, 32'd0);
    @(posedge clk);
    #1;
    check_eq("haz_after_rd1", read_data1, 32'd55);
    check_eq("haz_after_rd2", read_data2, 32'd55);
    drive_idle();

    // Boundary addresses 1 and 31.
    drive_write(5'd1, 32'h0000_0001);
    drive_write(5'd31, 32'h8000_0000);
    drive_idle();
    read_pair(5'd1, 5'd31);
    check_eq("bnd_r1", read_data1, 32'h0000_0001);
    check_eq("bnd_r31", read_data2, 32'h8000_0000);

    // Reset pulsed between edges, held across an edge with a write pending.
    read_pair(5'd10, 5'd11);
    check_eq("pre_rst_r10", read_data1, 32'd101);
    check_eq("pre_rst_r11", read_data2, 32'd200);
    drive_write(5'd12, 32'd77);
    #2 rst = 1'b0;
    #1;
    check_eq("async_r10", read_data1, 32'd0);
    check_eq("async_r11", read_data2, 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    en_write = 1'b0;
    repeat (2) @(negedge clk);
    read_pair(5'd10, 5'd11);
    check_eq("post_rst_r10", read_data1, 32'd0);
    check_eq("post_rst_r11", read_data2, 32'd0);
    read_pair(5'd12, 5'd5);
    check_eq("post_rst_r12", read_data1, 32'd0);
    check_eq("post_rst_r5", read_data2, 32'd0);

    // Sweep: a distinct value into every register, then read all back.
    for (int i = 1; i < 32; i++) begin
      drive_write(ADDR_W'(i), 32'hA500_0000 | 32'(i * 257));
      exp_q.push_back(32'hA500_0000 | 32'(i * 257));
    end
    drive_write(5'd0, 32'h1234_5678);
    drive_idle();
    read_pair(5'd0, 5'd0);
    check_eq("sweep_r0", read_data1, 32'd0);
    for (int i = 1; i < 32; i++) begin
      logic [DATA_W-1:0] exp_v;
      exp_v = exp_q.pop_front();
      read_pair(ADDR_W'(i), ADDR_W'(32 - i));
      check_eq($sformatf("sweep_rd1_r%0d", i), read_data1, exp_v);
      check_eq($sformatf("sweep_rd2_r%0d", 32 - i), read_data2,
               32'hA500_0000 | 32'((32 - i) * 257));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_register_file
